// File: rtl/uart_tx_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte FIFO that feeds a UART transmitter one frame at a time.
//               Optional synchronous flush enabled with UART_TXQ_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
  parameter int c_depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
`ifdef UART_TXQ_FLUSH_EN
  input  logic                     flush_i,
`endif
  input  logic                     wr_valid_i,
  input  logic [7:0]               wr_data_i,
  output logic                     wr_ready_o,
  output logic                     tx_start_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_done_tick_i,
  input  logic                     tx_active_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(c_depth):0] level_o
);

  localparam int c_addr_w = $clog2(c_depth);
  localparam int c_lvl_w  = c_addr_w + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [7:0]          r_mem [c_depth];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;
  state_t              r_state;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == c_lvl_w'(c_depth));
  assign w_empty = (r_level == '0);

`ifdef UART_TXQ_FLUSH_EN
  // A flush wins over both sides, so neither a write nor a pop may commit.
  assign w_push = wr_valid_i && !w_full && !flush_i;
  assign w_pop  = (r_state == IDLE) && !w_empty && !tx_active_i && !flush_i;
`else
  assign w_push = wr_valid_i && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty && !tx_active_i;
`endif

  assign wr_ready_o = !w_full;
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign level_o    = r_level;
  assign tx_start_o = r_tx_start;
  assign tx_data_o  = r_tx_data;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
`ifdef UART_TXQ_FLUSH_EN
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_mem[r_rd_ptr];
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done_tick_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Directed and random stimulus for uart_tx_queue against a
//               queue-based reference model (flush case with UART_TXQ_FLUSH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   wr_valid = 1'b0;
  logic [7:0]             wr_data = 8'h00;
  logic                   done = 1'b0;
  logic                   active = 1'b0;
  logic                   flush = 1'b0;
  logic                   wr_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] level;

  uart_tx_queue #(.c_depth(DEPTH)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
`ifdef UART_TXQ_FLUSH_EN
    .flush_i        (flush),
`endif
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_ready_o     (wr_ready),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .tx_done_tick_i (done),
    .tx_active_i    (active),
    .empty_o        (empty),
    .full_o         (full),
    .level_o        (level)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          start_cyc = 0;
  byte unsigned mq[$];
  byte unsigned sent[$];
  bit          m_wait  = 1'b0;
  bit          m_start = 1'b0;
  logic [7:0]  m_data  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":tx_start"}, tx_start, m_start);
    chk({tag, ":tx_data"},  tx_data,  m_data);
    chk({tag, ":level"},    level,    mq.size());
    chk({tag, ":empty"},    empty,    mq.size() == 0);
    chk({tag, ":full"},     full,     mq.size() == DEPTH);
    chk({tag, ":wr_ready"}, wr_ready, mq.size() != DEPTH);
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input string tag, input bit wv, input byte unsigned wd,
                       input bit dn, input bit act, input bit fl);
    bit acc;
    bit pop;
    wr_valid = wv; wr_data = wd; done = dn; active = act; flush = fl;
    acc = wv && (mq.size() < DEPTH) && !fl;
    pop = !m_wait && (mq.size() > 0) && !act && !fl;
    m_start = 1'b0;
    if (pop) begin
      m_data    = mq.pop_front();
      m_start   = 1'b1;
      m_wait    = 1'b1;
      start_cyc = cyc + 1;
    end else if (m_wait && dn) begin
      m_wait = 1'b0;
    end
    if (fl) mq.delete();
    if (acc) mq.push_back(wd);
    @(posedge clk); #1;
    cyc++;
    check_outputs(tag);
    if (tx_start === 1'b1) sent.push_back(tx_data);
  endtask

  // Run until the model is empty and idle; done ticks come gap edges after each start.
  task automatic drain(input string tag, input int gap);
    int budget;
    budget = 2000;
    while ((mq.size() > 0 || m_wait) && budget > 0) begin
      cycle(tag, 1'b0, 8'h00, m_wait && ((cyc + 1 - start_cyc) >= gap), 1'b0, 1'b0);
      budget--;
    end
    chk({tag, ":drained_empty"}, empty, 1'b1);
    chk({tag, ":drain_budget"}, budget > 0, 1'b1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 1'b0; m_start = 1'b0; m_data = 8'h00;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1; cyc++;
    check_outputs("post_reset");

    // Single byte into an empty queue: start appears two edges after acceptance.
    cycle("a5_write", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_no_fallthrough", tx_start, 1'b0);
    cycle("a5_start", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("a5_pulse", tx_start, 1'b1);
    chk("a5_data", tx_data, 8'hA5);
    cycle("a5_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("a5_one_cycle", tx_start, 1'b0);
    cycle("a5_done", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill to capacity with the transmitter busy; the 17th write is refused.
    for (int i = 0; i < 17; i++) begin
      cycle("fill", 1'b1, byte'(8'h10 + i), 1'b0, 1'b1, 1'b0);
    end
    chk("fill_level", level, 16);
    chk("fill_full", full, 1'b1);
    chk("fill_ready", wr_ready, 1'b0);

    // Full queue: pop and write on the same edge, the write is refused.
    cycle("pop_wr_full", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("pop_wr_level", level, 15);
    chk("pop_wr_data", tx_data, 8'h10);
    drain("drain_full", 3);

    // Five bytes, done tick ten cycles after each start.
    sent.delete();
    for (int i = 1; i <= 5; i++) begin
      cycle("seq_write", 1'b1, byte'(i), 1'b0, 1'b0, 1'b0);
    end
    drain("seq_drain", 10);
    chk("seq_count", sent.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("seq_order", (i < sent.size()) ? sent[i] : 8'hXX, i + 1);
    end

    // Reset in WAIT with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      cycle("rst_fill", 1'b1, byte'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    end
    chk("rst_pre_level", level, 3);
    wr_valid = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_data", tx_data, 8'h00);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1; cyc++;
    check_outputs("rst_release");
    cycle("rst_idle_write", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cycle("rst_idle_start", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_fsm_idle", tx_start, 1'b1);
    chk("rst_fsm_data", tx_data, 8'h3C);
    drain("rst_drain", 2);

    // Random traffic; done ticks also arrive while idle and must be ignored.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", $urandom_range(0, 9) < 6, byte'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end
    drain("rand_drain", 4);

`ifdef UART_TXQ_FLUSH_EN
    for (int i = 0; i < 6; i++) begin
      cycle("fl_fill", 1'b1, byte'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    end
    chk("fl_pre_level", level, 5);
    cycle("fl_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("fl_level", level, 0);
    chk("fl_data_kept", tx_data, 8'h60);
    cycle("fl_done", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("fl_quiet", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("fl_no_start", tx_start, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
- REQ-001 The block SHALL have parameter c_depth, default 16, giving the number of byte entries; legal values are powers of two ≥ 2.
- REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; every flop is rising-edge.
- REQ-003 The block SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
- REQ-004 The block SHALL have port wr_valid_i, input, 1 bit: producer offers the byte on wr_data_i.
- REQ-005 The block SHALL have port wr_data_i, input, 8 bits: byte to enqueue.
- REQ-006 The block SHALL have port wr_ready_o, output, 1 bit: the queue can accept a byte this cycle.
- REQ-007 The block SHALL have port tx_start_o, output, 1 bit: one-cycle start pulse to the transmitter's tx_start_i.
- REQ-008 The block SHALL have port tx_data_o, output, 8 bits: byte to the transmitter's tx_din_i.
- REQ-009 The block SHALL have port tx_done_tick_i, input, 1 bit: transmitter end-of-frame tick.
- REQ-010 The block SHALL have port tx_active_i, input, 1 bit: transmitter busy flag.
- REQ-011 The block SHALL have ports empty_o and full_o, outputs, 1 bit each: queue status.
- REQ-012 The block SHALL have port level_o, output, $clog2(c_depth)+1 bits: number of stored bytes.

Function
- REQ-013 A write SHALL be accepted on a rising edge where wr_valid_i=1 and wr_ready_o=1.
- REQ-014 wr_ready_o SHALL equal !full_o and SHALL NOT depend combinationally on wr_valid_i.
- REQ-015 Storage SHALL be a circular buffer with read and write pointers that wrap from c_depth-1 to 0.
- REQ-016 level_o SHALL range from 0 to c_depth; full_o SHALL equal (level_o==c_depth) and empty_o SHALL equal (level_o==0).
- REQ-017 The FSM SHALL have exactly the states IDLE and WAIT.
- REQ-018 In IDLE, when empty_o=0 and tx_active_i=0, the next edge SHALL pop one entry, set tx_start_o=1 and tx_data_o to the popped byte, and move the FSM to WAIT.
- REQ-019 tx_start_o SHALL be registered and SHALL be high for exactly one cycle per popped byte.
- REQ-020 In WAIT, tx_data_o SHALL hold its value, and tx_done_tick_i=1 SHALL return the FSM to IDLE on the next edge.
- REQ-021 In IDLE, tx_done_tick_i SHALL be ignored.
- REQ-022 There SHALL be no fall-through: a byte accepted at edge E into an empty queue with an idle transmitter SHALL produce tx_start_o high in the cycle between edges E+1 and E+2.
- REQ-023 When a write and a pop occur on the same edge, level_o SHALL be unchanged and both pointers SHALL advance.
- REQ-024 When the queue is full, a write SHALL be refused even if a pop occurs on the same edge.
- REQ-025 Bytes SHALL be delivered in strict FIFO order, with no loss or duplication.
- REQ-026 Back-to-back frames SHALL be separated by at least one IDLE cycle after tx_done_tick_i.

Reset
- REQ-027 While rstn_i=0, the block SHALL asynchronously drive tx_start_o=0, tx_data_o=8'h00, both pointers and level_o to 0, empty_o=1, full_o=0, wr_ready_o=1, and the FSM to IDLE.
- REQ-028 Reset in mid-operation SHALL discard all queued bytes and any pending WAIT state.
- REQ-029 Storage contents need not be reset.
- REQ-030 Reset release SHALL take effect on the first rising edge after rstn_i rises.

Configuration
- REQ-031 With macro UART_TXQ_FLUSH_EN defined, the block SHALL have an extra input flush_i (1 bit).
- REQ-032 With UART_TXQ_FLUSH_EN defined, flush_i=1 SHALL synchronously clear the pointers and level_o on the next edge and SHALL take priority over a simultaneous write or pop.
- REQ-033 flush_i SHALL NOT alter the FSM state or tx_data_o; a frame already started SHALL complete normally.
- REQ-034 Without UART_TXQ_FLUSH_EN, the port and its logic SHALL be absent, and behaviour SHALL be as specified in REQ-001 to REQ-030.

Verification
- REQ-035 The bench SHALL cover: write 8'hA5 into an empty queue with tx_active_i=0 -> tx_start_o pulses for one cycle, exactly 2 edges after acceptance, with tx_data_o=8'hA5.
- REQ-036 The bench SHALL cover: c_depth=16, 17 writes with the transmitter held active -> 16 accepted, full_o=1, level_o=16, wr_ready_o=0, 17th refused.
- REQ-037 The bench SHALL cover: bytes 8'h01..8'h05 queued, with tx_done_tick_i returned 10 cycles after each start -> five start pulses carrying 01..05 in order, then empty_o=1.
- REQ-038 The bench SHALL cover: full queue, pop and write on the same edge -> write refused, level_o=15 after the edge.
- REQ-039 The bench SHALL cover: rstn_i low in WAIT with level_o=3 -> level_o=0, empty_o=1, tx_start_o=0, FSM in IDLE immediately.
- REQ-040 The bench SHALL cover, with UART_TXQ_FLUSH_EN defined: flush_i pulsed with level_o=5 during WAIT -> level_o=0 on the next edge, tx_data_o unchanged, and no further start pulse after tx_done_tick_i.
